// File: rtl/sim_dmem_checker_if.sv
// Bundles the CPU data port, expected-table load port and checker status of sim_dmem_checker.
interface sim_dmem_checker_if;
    logic [31:0] d_mem_addr;
    logic [31:0] d_mem_wdata;
    logic [3:0]  d_mem_wen;
    logic [31:0] d_mem_rdata;
    logic        exp_we;
    logic [7:0]  exp_idx;
    logic [31:0] exp_data;
    logic        start_check;
    logic        check_busy;
    logic        check_done;
    logic        check_pass;
    logic [7:0]  fail_count;
    logic [7:0]  first_fail_idx;
    logic [15:0] wr_count;
    logic        oob_err;

    modport master (
        output d_mem_addr, d_mem_wdata, d_mem_wen, exp_we, exp_idx, exp_data, start_check,
        input  d_mem_rdata, check_busy, check_done, check_pass, fail_count, first_fail_idx,
               wr_count, oob_err
    );

    modport slave (
        input  d_mem_addr, d_mem_wdata, d_mem_wen, exp_we, exp_idx, exp_data, start_check,
        output d_mem_rdata, check_busy, check_done, check_pass, fail_count, first_fail_idx,
               wr_count, oob_err
    );
endinterface

// File: rtl/sim_dmem_checker.sv
// Data-memory model for cpu_top simulation with byte-lane writes, configurable read latency
// and a scanner that compares a result window against a table of expected words.
module sim_dmem_checker #(
    parameter int unsigned DEPTH_WORDS    = 1024,
    parameter logic [31:0] CHECK_BASE     = 32'h100,
    parameter int unsigned CHECK_COUNT    = 12,
    parameter int unsigned READ_LATENCY   = 0,
    parameter int unsigned TIMEOUT_CYCLES = 300
) (
    input  logic              clk,
    input  logic              rst_n,
    sim_dmem_checker_if.slave bus
);
    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned PIPE_N    = (READ_LATENCY == 0) ? 1 : READ_LATENCY;
    localparam logic [29:0] SCAN_BASE = CHECK_BASE[31:2];
    localparam logic [7:0]  LAST_K    = 8'(CHECK_COUNT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    logic [31:0]  r_mem [DEPTH_WORDS];
    logic [31:0]  r_exp_data [256];
    logic [255:0] r_exp_valid;
    logic [31:0]  r_rd_pipe [PIPE_N];

    state_t      r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic [7:0]  r_fail_count;
    logic [7:0]  r_first_fail;
    logic [7:0]  r_k;
    logic [31:0] r_to_cnt;
    logic        r_scan_started;
    logic [15:0] r_wr_count;
    logic        r_oob_err;

    logic [29:0] w_word_idx;
    logic        w_in_range;
    logic        w_wr_ok;
    logic [31:0] w_rd_word;
    logic [29:0] w_scan_word;
    logic        w_scan_in_range;
    logic [31:0] w_scan_mem;
    logic        w_mismatch;
    logic        w_to_fire;
    logic        w_enter_scan;
    logic        w_unused_addr_lsbs;

    // CPU port decode; the byte offset bits carry no meaning for a word memory
    assign w_word_idx         = bus.d_mem_addr[31:2];
    assign w_unused_addr_lsbs = ^bus.d_mem_addr[1:0];
    assign w_in_range         = (32'(w_word_idx) < DEPTH_WORDS);
    assign w_wr_ok            = rst_n && (bus.d_mem_wen != 4'b0000) && w_in_range;
    assign w_rd_word          = w_in_range ? r_mem[w_word_idx[AW-1:0]] : 32'h0;

    // Byte-lane write; memory contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (bus.d_mem_wen[b]) begin
                    r_mem[w_word_idx[AW-1:0]][8*b +: 8] <= bus.d_mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read pipeline samples the pre-write array contents
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < PIPE_N; i++) r_rd_pipe[i] <= 32'h0;
        end else begin
            r_rd_pipe[0] <= w_rd_word;
            for (int unsigned i = 1; i < PIPE_N; i++) r_rd_pipe[i] <= r_rd_pipe[i-1];
        end
    end

    assign bus.d_mem_rdata = (READ_LATENCY == 0) ? w_rd_word : r_rd_pipe[PIPE_N-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_count <= 16'h0;
            r_oob_err  <= 1'b0;
        end else begin
            if (w_wr_ok && (r_wr_count != 16'hFFFF)) r_wr_count <= r_wr_count + 16'd1;
            if (!w_in_range) r_oob_err <= 1'b1;
        end
    end

    // Expected table: data persists across reset, valid bits do not
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_exp_valid <= '0;
        end else if (bus.exp_we && (32'(bus.exp_idx) < CHECK_COUNT)) begin
            r_exp_valid[bus.exp_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && bus.exp_we && (32'(bus.exp_idx) < CHECK_COUNT)) begin
            r_exp_data[bus.exp_idx] <= bus.exp_data;
        end
    end

    assign w_scan_word     = SCAN_BASE + 30'(r_k);
    assign w_scan_in_range = (32'(w_scan_word) < DEPTH_WORDS);
    assign w_scan_mem      = w_scan_in_range ? r_mem[w_scan_word[AW-1:0]] : 32'h0;
    assign w_mismatch      = r_exp_valid[r_k] && (r_exp_data[r_k] != w_scan_mem);
    assign w_to_fire       = (TIMEOUT_CYCLES != 0) && !r_scan_started &&
                             (r_to_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_enter_scan    = ((r_state == IDLE) && (bus.start_check || w_to_fire)) ||
                             ((r_state == DONE) && bus.start_check);

    // Checker FSM; the timeout counter freezes once any scan has begun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_pass         <= 1'b0;
            r_fail_count   <= 8'h0;
            r_first_fail   <= 8'hFF;
            r_k            <= 8'h0;
            r_to_cnt       <= 32'h0;
            r_scan_started <= 1'b0;
        end else begin
            if (!r_scan_started && (TIMEOUT_CYCLES != 0)) r_to_cnt <= r_to_cnt + 32'd1;
            if (w_enter_scan) begin
                r_state        <= SCAN;
                r_busy         <= 1'b1;
                r_done         <= 1'b0;
                r_pass         <= 1'b0;
                r_fail_count   <= 8'h0;
                r_first_fail   <= 8'hFF;
                r_k            <= 8'h0;
                r_scan_started <= 1'b1;
            end else if (r_state == SCAN) begin
                if (w_mismatch) begin
                    r_fail_count <= r_fail_count + 8'd1;
                    if (r_fail_count == 8'h0) r_first_fail <= r_k;
                end
                if (r_k == LAST_K) begin
                    r_state <= DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (r_fail_count == 8'h0) && !w_mismatch;
                end else begin
                    r_k <= r_k + 8'd1;
                end
            end
        end
    end

    assign bus.check_busy     = r_busy;
    assign bus.check_done     = r_done;
    assign bus.check_pass     = r_pass;
    assign bus.fail_count     = r_fail_count;
    assign bus.first_fail_idx = r_first_fail;
    assign bus.wr_count       = r_wr_count;
    assign bus.oob_err        = r_oob_err;
endmodule

// File: tb/tb_sim_dmem_checker.sv
// Self-checking bench for sim_dmem_checker with READ_LATENCY=2 and TIMEOUT_CYCLES=20.
module tb_sim_dmem_checker;
    localparam int unsigned CHECK_COUNT = 12;
    localparam int unsigned DEPTH       = 1024;

    typedef struct {
        logic        chk;
        logic [31:0] val;
    } rd_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [15:0] exp_wr;
        logic        exp_oob;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    rd_exp_t     q[$];
    logic [31:0] model[int];

    always #5 clk = ~clk;

    sim_dmem_checker_if bus();

    sim_dmem_checker #(
        .DEPTH_WORDS   (DEPTH),
        .CHECK_BASE    (32'h100),
        .CHECK_COUNT   (CHECK_COUNT),
        .READ_LATENCY  (2),
        .TIMEOUT_CYCLES(20)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: predict this cycle's read, update the model, then score the read due now
    task automatic cycle();
        rd_exp_t     e;
        int unsigned idx;
        logic [31:0] w;
        idx   = 32'(bus.d_mem_addr[31:2]);
        e.chk = 1'b0;
        e.val = 32'h0;
        if (rst_n) begin
            if (idx >= DEPTH) begin
                e.chk = 1'b1;
            end else if (model.exists(int'(idx))) begin
                e.chk = 1'b1;
                e.val = model[int'(idx)];
            end
            if (bus.d_mem_wen != 4'b0000 && idx < DEPTH) begin
                w = model.exists(int'(idx)) ? model[int'(idx)] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (bus.d_mem_wen[b]) w[8*b +: 8] = bus.d_mem_wdata[8*b +: 8];
                model[int'(idx)] = w;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        if (!rst_n) foreach (q[i]) q[i].chk = 1'b0;
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.chk) check("rdata", bus.d_mem_rdata, e.val);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wen);
        bus.d_mem_addr  = addr;
        bus.d_mem_wdata = wdata;
        bus.d_mem_wen   = wen;
    endtask

    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic pass, input logic [7:0] fails, input logic [7:0] first);
        check({tag, "_busy"}, 32'(bus.check_busy), 32'(busy));
        check({tag, "_done"}, 32'(bus.check_done), 32'(done));
        check({tag, "_pass"}, 32'(bus.check_pass), 32'(pass));
        check({tag, "_fail_count"}, 32'(bus.fail_count), 32'(fails));
        check({tag, "_first_fail"}, 32'(bus.first_fail_idx), 32'(first));
    endtask

    // Pulse start_check, optionally write during compare wr_k and re-pulse start at restart_k
    task automatic run_scan(input string tag, input int wr_k, input logic [31:0] wr_addr,
                            input logic [31:0] wr_data, input int restart_k, input logic exp_pass,
                            input logic [7:0] exp_fails, input logic [7:0] exp_first);
        int n;
        bus.start_check = 1'b1;
        cycle();
        bus.start_check = 1'b0;
        check({tag, "_busy_start"}, 32'(bus.check_busy), 32'd1);
        check({tag, "_done_start"}, 32'(bus.check_done), 32'd0);
        n = 1;
        while (bus.check_done !== 1'b1 && n < 40) begin
            if (n - 1 == wr_k) drive(wr_addr, wr_data, 4'hF);
            if (n - 1 == restart_k) bus.start_check = 1'b1;
            cycle();
            drive(32'h100, 32'h0, 4'h0);
            bus.start_check = 1'b0;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(CHECK_COUNT + 1));
        check_status(tag, 1'b0, 1'b1, exp_pass, exp_fails, exp_first);
    endtask

    logic [31:0] exp_vals[CHECK_COUNT];
    vec_t        vecs[10];

    initial begin
        int n;
        exp_vals = '{32'd240, 32'd255, 32'd15, 32'd160, 32'd1525, 32'd1365,
                     32'd0, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FF00, 32'd170, 32'hFFFF_FFFF};
        vecs[0] = '{32'h000,  32'h0102_0304, 4'hF, 16'd1, 1'b0};
        vecs[1] = '{32'h100,  32'hAABB_CCDD, 4'hF, 16'd2, 1'b0};
        vecs[2] = '{32'h100,  32'h1122_3344, 4'h5, 16'd3, 1'b0};
        vecs[3] = '{32'h100,  32'h0,         4'h0, 16'd3, 1'b0};
        vecs[4] = '{32'h1000, 32'hDEAD_BEEF, 4'hF, 16'd3, 1'b1};
        vecs[5] = '{32'h000,  32'h0,         4'h0, 16'd3, 1'b1};
        vecs[6] = '{32'h104,  32'h0101_0101, 4'hF, 16'd4, 1'b1};
        vecs[7] = '{32'h104,  32'h5A00_0000, 4'h8, 16'd5, 1'b1};
        vecs[8] = '{32'h104,  32'h0,         4'h0, 16'd5, 1'b1};
        vecs[9] = '{32'h100,  32'h0,         4'h0, 16'd5, 1'b1};

        rst_n = 1'b0;
        drive(32'h0, 32'h0, 4'h0);
        bus.exp_we      = 1'b0;
        bus.exp_idx     = 8'h0;
        bus.exp_data    = 32'h0;
        bus.start_check = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;

        // Reset state, sampled in the first cycle after release
        check_status("reset", 1'b0, 1'b0, 1'b0, 8'h0, 8'hFF);
        check("reset_wr_count", 32'(bus.wr_count), 32'd0);
        check("reset_oob", 32'(bus.oob_err), 32'd0);
        check("reset_rdata", bus.d_mem_rdata, 32'h0);

        // Timeout scan: counter hits 19 in cycle 19, scan busy in cycle 20
        for (int i = 0; i < 19; i++) cycle();
        check("timeout_idle_c19", 32'(bus.check_busy), 32'd0);
        cycle();
        check("timeout_busy_c20", 32'(bus.check_busy), 32'd1);
        n = 0;
        while (bus.check_done !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        check("timeout_scan_len", 32'(n), 32'(CHECK_COUNT));
        check_status("timeout", 1'b0, 1'b1, 1'b1, 8'h0, 8'hFF);

        // Byte lanes, read latency and out-of-range accesses
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].wen);
            cycle();
            check($sformatf("vec%0d_wr_count", i), 32'(bus.wr_count), 32'(vecs[i].exp_wr));
            check($sformatf("vec%0d_oob", i), 32'(bus.oob_err), 32'(vecs[i].exp_oob));
        end
        drive(32'h100, 32'h0, 4'h0);
        cycle();
        cycle();
        check("byte_lane_direct", bus.d_mem_rdata, 32'hAA22_CC44);

        // Load expected table and matching result words together
        for (int k = 0; k < int'(CHECK_COUNT); k++) begin
            drive(32'h100 + 32'(4 * k), exp_vals[k], 4'hF);
            bus.exp_we   = 1'b1;
            bus.exp_idx  = 8'(k);
            bus.exp_data = exp_vals[k];
            cycle();
        end
        bus.exp_idx  = 8'd12;
        bus.exp_data = 32'h1234_5678;
        drive(32'h100, 32'h0, 4'h0);
        cycle();
        bus.exp_we = 1'b0;
        cycle();

        run_scan("pass", -1, 32'h0, 32'h0, -1, 1'b1, 8'd0, 8'hFF);

        drive(32'h108, 32'hDEAD_0000, 4'hF);
        cycle();
        drive(32'h124, 32'h1234_5678, 4'hF);
        cycle();
        drive(32'h100, 32'h0, 4'h0);
        run_scan("fail", -1, 32'h0, 32'h0, -1, 1'b0, 8'd2, 8'd2);

        // Same-cycle fix of word 2 is not seen; start_check during SCAN is ignored
        drive(32'h124, 32'hFFFF_FF00, 4'hF);
        cycle();
        drive(32'h100, 32'h0, 4'h0);
        run_scan("race", 2, 32'h108, 32'd15, 5, 1'b0, 8'd1, 8'd2);
        run_scan("recheck", -1, 32'h0, 32'h0, -1, 1'b1, 8'd0, 8'hFF);

        // Reset mid-scan; memory retained, valid bits cleared
        drive(32'h124, 32'h0BAD_F00D, 4'hF);
        cycle();
        drive(32'h100, 32'h0, 4'h0);
        bus.start_check = 1'b1;
        cycle();
        bus.start_check = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("midscan_busy_before", 32'(bus.check_busy), 32'd1);
        rst_n = 1'b0;
        cycle();
        check_status("midrst", 1'b0, 1'b0, 1'b0, 8'h0, 8'hFF);
        check("midrst_wr_count", 32'(bus.wr_count), 32'd0);
        check("midrst_oob", 32'(bus.oob_err), 32'd0);
        rst_n = 1'b1;
        drive(32'h124, 32'h0, 4'h0);
        cycle();
        drive(32'h108, 32'h0, 4'h0);
        cycle();
        drive(32'h2000, 32'h0, 4'h0);
        cycle();
        check("oob_read", 32'(bus.oob_err), 32'd1);
        drive(32'h100, 32'h0, 4'h0);
        cycle();
        cycle();
        check("retained_0x100", bus.d_mem_rdata, 32'd240);
        run_scan("postrst", -1, 32'h0, 32'h0, -1, 1'b1, 8'd0, 8'hFF);
        cycle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
